bram2axis_sched: RTL



---
 rtl/bram2axis_sched.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/bram2axis_sched.sv
// bram2axis_sched: buffers transfer descriptors in a small FIFO and sequences them,
// one at a time, onto a bank of BRAM-to-AXI4-Stream readout engines.
module bram2axis_sched #(
  parameter int NUM_CH          = 4,
  parameter int CH_W            = 2,
  parameter int XFER_SIZE_WIDTH = 32,
  parameter int DATA_BYTES      = 16,
  parameter int CMD_DEPTH       = 4,
  parameter int ACK_TIMEOUT     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_cmd_valid,
  output logic                       o_cmd_ready,
  input  logic [CH_W-1:0]            i_cmd_ch,
  input  logic [XFER_SIZE_WIDTH-1:0] i_cmd_size,
  output logic [NUM_CH-1:0]          o_start,
  input  logic [NUM_CH-1:0]          i_done,
  output logic [XFER_SIZE_WIDTH-1:0] o_size,
  output logic                       o_busy,
  output logic [CH_W-1:0]            o_cur_ch,
  output logic                       o_cmpl_valid,
  output logic [CH_W-1:0]            o_cmpl_ch,
  output logic [15:0]                o_xfer_cnt,
  output logic [1:0]                 o_err,
  input  logic                       i_err_clr
);

  localparam int AW = $clog2(CMD_DEPTH);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CH_W:0]            LP_NUM_CH  = (CH_W + 1)'(NUM_CH);
  localparam logic [XFER_SIZE_WIDTH-1:0] LP_DBYTES = XFER_SIZE_WIDTH'(DATA_BYTES);
  localparam logic [AW:0]              LP_DEPTH   = (AW + 1)'(CMD_DEPTH);
  localparam logic [TW-1:0]            LP_TO_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_ACK  = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  logic [CH_W-1:0]            r_fifo_ch   [CMD_DEPTH];
  logic [XFER_SIZE_WIDTH-1:0] r_fifo_size [CMD_DEPTH];
  logic [AW:0]                r_wr_ptr;
  logic [AW:0]                r_rd_ptr;
  state_t                     r_state;
  logic [TW-1:0]              r_ack_cnt;
  logic [NUM_CH-1:0]          r_start;
  logic [XFER_SIZE_WIDTH-1:0] r_size;
  logic                       r_busy;
  logic [CH_W-1:0]            r_cur_ch;
  logic                       r_cmpl_valid;
  logic [CH_W-1:0]            r_cmpl_ch;
  logic [15:0]                r_xfer_cnt;
  logic [1:0]                 r_err;

  logic                       w_full;
  logic                       w_empty;
  logic                       w_accept;
  logic                       w_illegal;
  logic                       w_push;
  logic                       w_pop;
  logic                       w_timeout;
  logic                       w_cur_done;
  logic [CH_W-1:0]            w_head_ch;
  logic [XFER_SIZE_WIDTH-1:0] w_head_size;
  logic [NUM_CH-1:0]          w_onehot;

  assign w_full      = ((r_wr_ptr - r_rd_ptr) == LP_DEPTH);
  assign w_empty     = (r_wr_ptr == r_rd_ptr);
  assign w_head_ch   = r_fifo_ch[r_rd_ptr[AW-1:0]];
  assign w_head_size = r_fifo_size[r_rd_ptr[AW-1:0]];
  assign w_cur_done  = i_done[r_cur_ch];

  // Illegal descriptors are still consumed so a bad host cannot wedge the port.
  assign w_illegal = (i_cmd_size == {XFER_SIZE_WIDTH{1'b0}}) ||
                     ((i_cmd_size % LP_DBYTES) != {XFER_SIZE_WIDTH{1'b0}}) ||
                     ({1'b0, i_cmd_ch} >= LP_NUM_CH);
  assign w_accept  = i_cmd_valid && !w_full;
  assign w_push    = w_accept && !w_illegal;
  // Only the head is considered, so a busy head engine blocks everything behind it.
  assign w_pop     = (r_state == S_IDLE) && !w_empty && i_done[w_head_ch];
  assign w_timeout = (r_state == S_WAIT_ACK) && w_cur_done && (r_ack_cnt == LP_TO_LAST);

  // One-hot start vector for the head channel
  always_comb begin
    w_onehot = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_head_ch == CH_W'(i)) begin
        w_onehot[i] = 1'b1;
      end else begin
        w_onehot[i] = 1'b0;
      end
    end
  end

  // Descriptor storage; contents need no reset since the pointers gate validity
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_ch[r_wr_ptr[AW-1:0]]   <= i_cmd_ch;
      r_fifo_size[r_wr_ptr[AW-1:0]] <= i_cmd_size;
    end
  end

  // FIFO pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= {(AW + 1){1'b0}};
      r_rd_ptr <= {(AW + 1){1'b0}};
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      if (w_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Sticky error flags; a new event outranks a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 2'b00;
    end else begin
      r_err <= (r_err & {2{~i_err_clr}}) | {w_timeout, (w_accept && w_illegal)};
    end
  end

  // Transfer sequencer with registered engine-facing and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ack_cnt    <= {TW{1'b0}};
      r_start      <= {NUM_CH{1'b0}};
      r_size       <= {XFER_SIZE_WIDTH{1'b0}};
      r_busy       <= 1'b0;
      r_cur_ch     <= {CH_W{1'b0}};
      r_cmpl_valid <= 1'b0;
      r_cmpl_ch    <= {CH_W{1'b0}};
      r_xfer_cnt   <= 16'd0;
    end else begin
      r_start      <= {NUM_CH{1'b0}};
      r_cmpl_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_cur_ch <= w_head_ch;
            r_size   <= w_head_size;
            r_start  <= w_onehot;
            r_busy   <= 1'b1;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_ack_cnt <= {TW{1'b0}};
          r_state   <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (!w_cur_done) begin
            r_state <= S_WAIT_DONE;
          end else if (w_timeout) begin
            // Engine never acknowledged: report completion so the host is not left hanging.
            r_cmpl_valid <= 1'b1;
            r_cmpl_ch    <= r_cur_ch;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end else begin
            r_ack_cnt <= r_ack_cnt + {{(TW - 1){1'b0}}, 1'b1};
          end
        end
        S_WAIT_DONE: begin
          if (w_cur_done) begin
            r_cmpl_valid <= 1'b1;
            r_cmpl_ch    <= r_cur_ch;
            r_xfer_cnt   <= r_xfer_cnt + 16'd1;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_cmd_ready  = !w_full;
  assign o_start      = r_start;
  assign o_size       = r_size;
  assign o_busy       = r_busy;
  assign o_cur_ch     = r_cur_ch;
  assign o_cmpl_valid = r_cmpl_valid;
  assign o_cmpl_ch    = r_cmpl_ch;
  assign o_xfer_cnt   = r_xfer_cnt;
  assign o_err        = r_err;

endmodule
